alu_nibble_seq_ctrl: RTL and testbench



---
 rtl/alu_nibble_seq_ctrl.sv | 101 ++++++++++
 tb/tb_alu_nibble_seq_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_seq_ctrl.sv
// Multi-cycle add/subtract built from one SLICE-bit adder stepped per clock.
// Start/busy/done handshake; result plus carry, overflow and zero flags.
module alu_nibble_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_q, b_q;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [SLICE-1:0] a_sl, b_sl, s;
  logic             c;
  logic             c_msb;
  logic [WIDTH-1:0] res_nx;

  // b_q holds the already-inverted operand for subtract
  always_comb begin
    a_sl   = a_q[cnt*SLICE +: SLICE];
    b_sl   = b_q[cnt*SLICE +: SLICE];
    {c, s} = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry);
    c_msb  = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ s[SLICE-1];
    res_nx = result;
    res_nx[cnt*SLICE +: SLICE] = s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (cnt == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      result <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          a_q   <= a;
          b_q   <= sub ? ~b : b;
          carry <= sub;
          cnt   <= '0;
        end
        RUN: begin
          result <= res_nx;
          carry  <= c;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            cout <= c;
            ovf  <= c_msb ^ c;
            zero <= (res_nx == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_seq_ctrl.sv
// Bench for alu_nibble_seq_ctrl: directed corner cases plus random
// operations checked against a plain 33-bit arithmetic model.
module tb_alu_nibble_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sub = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, cout, ovf, zero;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  alu_nibble_seq_ctrl #(.WIDTH(32), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub),
    .a(a), .b(b), .busy(busy), .done(done),
    .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input logic s, output logic [31:0] r,
                                output logic c, output logic o,
                                output logic z);
    logic [32:0] w;
    longint sx, sy, sr;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    if (s) begin
      w  = {1'b0, x} + {1'b0, ~y} + 33'd1;
      sr = sx - sy;
    end else begin
      w  = {1'b0, x} + {1'b0, y};
      sr = sx + sy;
    end
    r = w[31:0];
    c = w[32];
    o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    z = (r == 32'd0);
  endfunction

  logic [31:0] m_r;
  logic        m_c, m_o, m_z;

  task automatic do_op(input string tag, input logic [31:0] ta,
                       input logic [31:0] tb_, input logic ts);
    int lat, bcnt;
    model(ta, tb_, ts, m_r, m_c, m_o, m_z);
    @(negedge clk);
    a = ta; b = tb_; sub = ts; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    a = $urandom; b = $urandom; sub = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!done && lat < 20) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1 lat++;
    end
    chk({tag, "_lat"}, lat, 8);
    chk({tag, "_busy"}, bcnt, 8);
    chk({tag, "_res"}, result, m_r);
    chk({tag, "_cout"}, 32'(cout), 32'(m_c));
    chk({tag, "_ovf"}, 32'(ovf), 32'(m_o));
    chk({tag, "_zero"}, 32'(zero), 32'(m_z));
    @(posedge clk);
    #1 chk({tag, "_pulse"}, 32'(done), 0);
  endtask

  initial begin
    int dn;
    logic [31:0] cap;
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_res", result, 0);
    chk("rst_flags", {29'd0, cout, ovf, zero}, 0);
    @(negedge clk) rst = 1'b0;

    do_op("add1", 32'h1, 32'hF, 1'b0);
    chk("add1_k", result, 32'h10);
    do_op("addw", 32'hFFFFFFFF, 32'h1, 1'b0);
    chk("addw_k", {result[3:0], cout, zero, ovf}, {4'h0, 3'b110});
    do_op("addo", 32'h7FFFFFFF, 32'h1, 1'b0);
    chk("addo_k", {result, 1'b0}, {32'h80000000, 1'b0});
    chk("addo_f", {30'd0, ovf, cout}, 2);
    do_op("sub1", 32'h5, 32'h7, 1'b1);
    chk("sub1_k", result, 32'hFFFFFFFE);
    do_op("sub2", 32'h7, 32'h7, 1'b1);
    chk("sub2_k", {29'd0, zero, cout, ovf}, 3'b110);
    do_op("sub3", 32'h80000000, 32'h1, 1'b1);
    chk("sub3_k", result, 32'h7FFFFFFF);
    chk("sub3_o", 32'(ovf), 1);

    // start and operand changes during RUN must be ignored
    @(negedge clk);
    a = 32'h10; b = 32'h20; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dn = 0; cap = '0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin dn++; cap = result; end
      if (i == 3) begin
        start = 1'b1; a = 32'hAAAAAAAA; b = $urandom; sub = 1'b1;
      end
      if (i == 4) start = 1'b0;
    end
    chk("ign_dones", dn, 1);
    chk("ign_res", cap, 32'h30);

    // start held high re-arms on the first IDLE cycle
    @(negedge clk);
    a = 32'h1; b = 32'h2; sub = 1'b0; start = 1'b1;
    dn = 0;
    while (!done && dn < 20) begin @(posedge clk); #1 dn++; end
    chk("hold_res", result, 32'h3);
    @(posedge clk);
    #1 chk("hold_idle", {30'd0, busy, done}, 0);
    @(posedge clk);
    #1 chk("hold_rearm", 32'(busy), 1);
    start = 1'b0;
    dn = 0;
    while (!done && dn < 20) begin @(posedge clk); #1 dn++; end
    chk("hold_res2", result, 32'h3);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_res", result, 0);
    chk("arst_flags", {29'd0, cout, ovf, zero}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    dn = 0;
    repeat (12) begin @(posedge clk); #1 if (done) dn++; end
    chk("arst_nodone", dn, 0);
    do_op("post", 32'h12345678, 32'h11111111, 1'b0);
    chk("post_k", result, 32'h23456789);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) rb = ra;
      if (i % 7 == 0) rb = ~ra + 32'd1;
      do_op("rnd", ra, rb, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
